// File: rtl/mem_share_arbiter.sv
// Round-robin arbiter sharing one single-port memory between requesters A and B.
// Each grant performs exactly one access: IDLE -> ACCESS -> RESP -> IDLE, all outputs registered.
module mem_share_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_err,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_err,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic                  ptr_b_q,     ptr_b_d;
    logic                  win_b_q,     win_b_d;
    logic                  in_range_q,  in_range_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  a_ack_q,     a_ack_d;
    logic [DATA_WIDTH-1:0] a_rdata_q,   a_rdata_d;
    logic                  a_err_q,     a_err_d;
    logic                  b_ack_q,     b_ack_d;
    logic [DATA_WIDTH-1:0] b_rdata_q,   b_rdata_d;
    logic                  b_err_q,     b_err_d;
    logic                  busy_q,      busy_d;

    logic                  grant_b;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_in_range;
    logic [DATA_WIDTH-1:0] acc_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_b_q     <= 1'b0;
            win_b_q     <= 1'b0;
            in_range_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            a_err_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            b_rdata_q   <= '0;
            b_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_b_q     <= ptr_b_d;
            win_b_q     <= win_b_d;
            in_range_q  <= in_range_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_ack_q     <= a_ack_d;
            a_rdata_q   <= a_rdata_d;
            a_err_q     <= a_err_d;
            b_ack_q     <= b_ack_d;
            b_rdata_q   <= b_rdata_d;
            b_err_q     <= b_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_b_d     = ptr_b_q;
        win_b_d     = win_b_q;
        in_range_d  = in_range_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        a_err_d     = a_err_q;
        b_ack_d     = 1'b0;
        b_rdata_d   = b_rdata_q;
        b_err_d     = b_err_q;

        // B wins only when A is absent or both request and the pointer names B.
        grant_b      = b_req && (!a_req || ptr_b_q);
        sel_we       = grant_b ? b_we    : a_we;
        sel_addr     = grant_b ? b_addr  : a_addr;
        sel_wdata    = grant_b ? b_wdata : a_wdata;
        sel_in_range = (32'(sel_addr) < MEM_DEPTH);
        acc_rdata    = in_range_q ? mem_rdata : '0;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    win_b_d     = grant_b;
                    in_range_d  = sel_in_range;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we && sel_in_range;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // mem_rdata still shows the pre-write contents on this edge.
                if (win_b_q) begin
                    b_ack_d   = 1'b1;
                    b_rdata_d = acc_rdata;
                    b_err_d   = !in_range_q;
                end else begin
                    a_ack_d   = 1'b1;
                    a_rdata_d = acc_rdata;
                    a_err_d   = !in_range_q;
                end
                state_d = RESP;
            end
            RESP: begin
                ptr_b_d = !win_b_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign a_ack     = a_ack_q;
    assign a_rdata   = a_rdata_q;
    assign a_err     = a_err_q;
    assign b_ack     = b_ack_q;
    assign b_rdata   = b_rdata_q;
    assign b_err     = b_err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Self-checking bench for mem_share_arbiter: vector table plus multi-cycle sequences,
// with a scoreboard queue of expected acks checked by a negedge monitor.
module tb_mem_share_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_ack, a_err;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack, b_err;
    logic [DW-1:0] b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    logic [DW-1:0] tb_mem [0:255];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int a_acks = 0;
    int b_acks = 0;

    typedef struct {
        logic          port_b;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          port_b;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_we_cycles;
    } vec_t;
    vec_t vec [13];

    logic [DW-1:0] last_a_rd = '0, last_b_rd = '0;
    logic          last_a_err = 1'b0, last_b_err = 1'b0;

    mem_share_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .a_err    (a_err),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .b_err    (b_err),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = tb_mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks that idle rdata/err hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_a_rd = '0; last_a_err = 1'b0;
            last_b_rd = '0; last_b_err = 1'b0;
        end else begin
            if (mem_we) we_cnt++;
            chk("ack_overlap", {31'd0, a_ack && b_ack}, 32'd0);
            if (a_ack) begin
                a_acks++;
                if (sb.size() == 0) chk("a_unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("a_ack_port", 32'd0, {31'd0, e.port_b});
                    chk("a_rdata", {24'd0, a_rdata}, {24'd0, e.rdata});
                    chk("a_err", {31'd0, a_err}, {31'd0, e.err});
                end
                last_a_rd = a_rdata; last_a_err = a_err;
            end else begin
                chk("a_rdata_hold", {24'd0, a_rdata}, {24'd0, last_a_rd});
                chk("a_err_hold", {31'd0, a_err}, {31'd0, last_a_err});
            end
            if (b_ack) begin
                b_acks++;
                if (sb.size() == 0) chk("b_unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("b_ack_port", 32'd1, {31'd0, e.port_b});
                    chk("b_rdata", {24'd0, b_rdata}, {24'd0, e.rdata});
                    chk("b_err", {31'd0, b_err}, {31'd0, e.err});
                end
                last_b_rd = b_rdata; last_b_err = b_err;
            end else begin
                chk("b_rdata_hold", {24'd0, b_rdata}, {24'd0, last_b_rd});
                chk("b_err_hold", {31'd0, b_err}, {31'd0, last_b_err});
            end
        end
    end

    task automatic push_exp(input logic pb, input logic [DW-1:0] rd, input logic er);
        exp_t e;
        e.port_b = pb; e.rdata = rd; e.err = er;
        sb.push_back(e);
    endtask

    task automatic drive(input logic pb, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic req);
        if (pb) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
        else    begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            chk("sb_drained_before_reset", sb.size(), 32'd0);
            sb.delete();
        end
        rst_n = 1'b1;
    endtask

    // Single request from an idle arbiter; checks latency, memory pins and write pulses.
    task automatic do_req(input vec_t v, input string tag);
        int n;
        int we0;
        logic got;
        @(negedge clk);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        we0 = we_cnt;
        drive(v.port_b, v.we, v.addr, v.wdata, 1'b1);
        push_exp(v.port_b, v.exp_rdata, v.exp_err);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_busy_access"}, {31'd0, busy}, 32'd1);
                chk({tag, "_mem_addr"}, {24'd0, mem_addr}, {24'd0, v.addr});
                if (v.we) chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, {24'd0, v.wdata});
            end
            got = v.port_b ? b_ack : a_ack;
        end
        drive(v.port_b, v.we, v.addr, v.wdata, 1'b0);
        chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_latency"}, n, 32'd2);
        chk({tag, "_we_cycles"}, we_cnt - we0, v.exp_we_cycles);
    endtask

    initial begin
        int n, k, acks0;
        vec_t v;

        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, acks0, we0;
        vec_t v;

        for (int unsigned i = 0; i < 256; i++) tb_mem[i] = DW'(i) ^ 8'hA5;

        //        port  we    addr   wdata  rdata  err   we_cycles
        vec[0]  = '{1'b0, 1'b1, 8'd5,  8'd45, 8'hA0, 1'b0, 1};
        vec[1]  = '{1'b1, 1'b1, 8'd0,  8'd77, 8'hA5, 1'b0, 1};
        vec[2]  = '{1'b1, 1'b1, 8'd3,  8'd32, 8'hA6, 1'b0, 1};
        vec[3]  = '{1'b0, 1'b0, 8'd5,  8'd0,  8'd45, 1'b0, 0};
        vec[4]  = '{1'b1, 1'b0, 8'd0,  8'd0,  8'd77, 1'b0, 0};
        vec[5]  = '{1'b1, 1'b0, 8'd3,  8'd0,  8'd32, 1'b0, 0};
        vec[6]  = '{1'b0, 1'b1, 8'd20, 8'd12, 8'h00, 1'b1, 0};
        vec[7]  = '{1'b0, 1'b0, 8'd10, 8'd0,  8'hAF, 1'b0, 0};
        vec[8]  = '{1'b1, 1'b0, 8'd20, 8'd0,  8'h00, 1'b1, 0};
        vec[9]  = '{1'b0, 1'b1, 8'd15, 8'h5A, 8'hAA, 1'b0, 1};
        vec[10] = '{1'b1, 1'b0, 8'd15, 8'd0,  8'h5A, 1'b0, 0};
        vec[11] = '{1'b0, 1'b1, 8'd16, 8'h11, 8'h00, 1'b1, 0};
        vec[12] = '{1'b0, 1'b0, 8'd0,  8'd0,  8'd77, 1'b0, 0};

        repeat (2) @(negedge clk);
        chk("rst_outputs_low", {22'd0, a_ack, a_err, b_ack, b_err, mem_we, busy, 4'd0},
            32'd0);
        chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
        chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;

        foreach (vec[i]) do_req(vec[i], $sformatf("vec%0d", i));
        chk("oob_write_untouched", {24'd0, tb_mem[20]}, 32'hB1);
        chk("oob16_write_untouched", {24'd0, tb_mem[16]}, 32'hB5);

        // Both requesting from reset: A first, then strict alternation.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) push_exp(i[0], (i[0] ? 8'hA7 : 8'hA4), 1'b0);
        drive(1'b0, 1'b0, 8'd1, 8'd0, 1'b1);
        drive(1'b1, 1'b0, 8'd2, 8'd0, 1'b1);
        n = 0; k = 0;
        while (k < 6 && n < 60) begin
            @(negedge clk);
            n++;
            if (a_ack || b_ack) k++;
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("rr_six_grants", k, 32'd6);
        chk("rr_cycles", n, 32'd17);
        @(negedge clk);
        chk("rr_sb_empty", sb.size(), 32'd0);

        // Reset asserted while a write to @7 is in ACCESS.
        @(negedge clk);
        acks0 = a_acks + b_acks;
        drive(1'b0, 1'b1, 8'd7, 8'h33, 1'b1);
        @(posedge clk);
        #1;
        chk("abort_we_in_access", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async_drop", {31'd0, mem_we}, 32'd0);
        chk("abort_busy_drop", {31'd0, busy}, 32'd0);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_ack", (a_acks + b_acks) - acks0, 32'd0);
        v = '{1'b0, 1'b0, 8'd7, 8'd0, 8'hA2, 1'b0, 0};
        do_req(v, "abort_readback");

        // A drops its request during ACCESS; the access still completes exactly once.
        @(negedge clk);
        acks0 = a_acks;
        we0 = we_cnt;
        drive(1'b0, 1'b0, 8'd3, 8'd0, 1'b1);
        push_exp(1'b0, 8'd32, 1'b0);
        @(negedge clk);
        a_req = 1'b0;
        n = 1;
        while (!a_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drop_ack_latency", n, 32'd2);
        repeat (5) @(negedge clk);
        chk("drop_single_ack", a_acks - acks0, 32'd1);
        chk("drop_no_write", we_cnt - we0, 32'd0);
        chk("drop_idle_after", {31'd0, busy}, 32'd0);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
